// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port 16-bit synchronous RAM between two block-transfer
// clients. Each granted burst moves up to MAX_WORDS words, one per cycle, packed MSB-first.
module ram_access_arbiter #(
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic         clock,
    input  logic         reset_n,

    input  logic         c0_start,
    input  logic         c0_write,
    input  logic [15:0]  c0_address,
    input  logic [15:0]  c0_words,
    input  logic [255:0] c0_wdata,
    output logic [255:0] c0_rdata,
    output logic         c0_done,

    input  logic         c1_start,
    input  logic         c1_write,
    input  logic [15:0]  c1_address,
    input  logic [15:0]  c1_words,
    input  logic [255:0] c1_wdata,
    output logic [255:0] c1_rdata,
    output logic         c1_done,

    output logic [15:0]  mem_address,
    output logic [15:0]  mem_wdata,
    output logic         mem_we,
    input  logic [15:0]  mem_rdata,

    output logic         busy,
    output logic         grant
);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

    localparam logic [4:0] MaxCount = 5'(MAX_WORDS);

    state_e       state_q, state_d;
    logic         grant_q, grant_d;
    logic         rr_q, rr_d;
    logic         write_q, write_d;
    logic [255:0] wdata_q, wdata_d;
    logic [4:0]   count_q, count_d;
    logic [4:0]   idx_q, idx_d;
    logic         c0_done_q, c0_done_d;
    logic         c1_done_q, c1_done_d;
    logic [255:0] c0_rdata_q, c0_rdata_d;
    logic [255:0] c1_rdata_q, c1_rdata_d;
    logic [15:0]  mem_address_q, mem_address_d;
    logic [15:0]  mem_wdata_q, mem_wdata_d;
    logic         mem_we_q, mem_we_d;

    logic         sel;
    logic         gnt_start;
    logic         capture;
    logic [3:0]   cap_idx;
    logic [4:0]   next_idx;
    logic [15:0]  sel_address;
    logic [4:0]   sel_count;
    logic [255:0] sel_wdata;

    // Bit offset of the LSB of word j inside a 256-bit MSB-first packed bus.
    function automatic logic [7:0] word_lsb(input logic [3:0] j);
        return 8'd240 - {j, 4'b0000};
    endfunction

    function automatic logic [4:0] clamp_words(input logic [15:0] words);
        return (words > 16'(MAX_WORDS)) ? MaxCount : words[4:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        count_d       = count_q;
        idx_d         = idx_q;
        c0_done_d     = c0_done_q;
        c1_done_d     = c1_done_q;
        c0_rdata_d    = c0_rdata_q;
        c1_rdata_d    = c1_rdata_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;

        // With both requesting, rr_q names the client that was not granted last.
        sel         = c1_start & (~c0_start | rr_q);
        gnt_start   = grant_q ? c1_start : c0_start;
        cap_idx     = idx_q[3:0] - 4'd1;
        next_idx    = idx_q + 5'd1;
        sel_address = sel ? c1_address : c0_address;
        sel_count   = clamp_words(sel ? c1_words : c0_words);
        sel_wdata   = sel ? c1_wdata : c0_wdata;
        capture     = ((state_q == StXfer) && !write_q && (idx_q != 5'd0)) ||
                      (state_q == StDrain);

        unique case (state_q)
            StIdle: begin
                if (c0_start || c1_start) begin
                    grant_d = sel;
                    rr_d    = ~sel;
                    write_d = sel ? c1_write : c0_write;
                    wdata_d = sel_wdata;
                    count_d = sel_count;
                    idx_d   = 5'd0;
                    if (sel) begin
                        c1_rdata_d = '0;
                    end else begin
                        c0_rdata_d = '0;
                    end
                    if (sel_count == 5'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d       = StXfer;
                        mem_address_d = sel_address;
                        mem_we_d      = write_d;
                        if (write_d) begin
                            mem_wdata_d = sel_wdata[255:240];
                        end
                    end
                end
            end
            StXfer: begin
                idx_d = next_idx;
                if (next_idx == count_q) begin
                    state_d = write_q ? StDone : StDrain;
                end else begin
                    mem_address_d = mem_address_q + 16'd1;
                    mem_we_d      = write_q;
                    if (write_q) begin
                        mem_wdata_d = wdata_q[word_lsb(next_idx[3:0]) +: 16];
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                // First cycle in DONE raises done; it then holds until start is seen low.
                if (!(c0_done_q || c1_done_q)) begin
                    if (grant_q) begin
                        c1_done_d = 1'b1;
                    end else begin
                        c0_done_d = 1'b1;
                    end
                end else if (!gnt_start) begin
                    state_d   = StIdle;
                    c0_done_d = 1'b0;
                    c1_done_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The word addressed in the previous cycle is on mem_rdata now.
        if (capture) begin
            if (grant_q) begin
                c1_rdata_d[word_lsb(cap_idx) +: 16] = mem_rdata;
            end else begin
                c0_rdata_d[word_lsb(cap_idx) +: 16] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            rr_q          <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            c0_done_q     <= 1'b0;
            c1_done_q     <= 1'b0;
            c0_rdata_q    <= '0;
            c1_rdata_q    <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            c0_done_q     <= c0_done_d;
            c1_done_q     <= c1_done_d;
            c0_rdata_q    <= c0_rdata_d;
            c1_rdata_q    <= c1_rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
        end
    end

    assign c0_rdata    = c0_rdata_q;
    assign c1_rdata    = c1_rdata_q;
    assign c0_done     = c0_done_q;
    assign c1_done     = c1_done_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign busy        = (state_q != StIdle);
    assign grant       = grant_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares one single-port 16-bit synchronous RAM between two block-transfer clients: client 0 (instruction fetch) and client 1 (stack load/store and register spill/fill).
- Each client uses a level start/done handshake and moves 1..16 words, packed MSB-first into a 256-bit bus.
- The arbiter grants one client round-robin, then sequences the burst one word per cycle onto the RAM port.
- It sits between the CPU control FSM and the RAM.

Parameters:
- MAX_WORDS, 16, maximum words per transfer. Any larger request is clamped to this value. It must be ≤ 16.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- c0_start  in  1  client 0 request, held high until c0_done seen
- c0_write  in  1  client 0 direction: 1 = write, 0 = read
- c0_address  in  16  client 0 base word address
- c0_words  in  16  client 0 word count
- c0_wdata  in  256  client 0 write data; word i = bits [255-16i -: 16]
- c0_rdata  out  256  client 0 read data, same packing
- c0_done  out  1  client 0 completion
- c1_start, c1_write, c1_address, c1_words, c1_wdata, c1_rdata, c1_done: same as client 0, for client 1
- mem_address  out  16  RAM word address
- mem_wdata  out  16  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  16  RAM read data, valid one cycle after its address is driven
- busy  out  1  a transfer is in progress (state is not IDLE)
- grant  out  1  index of the client last or currently granted

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs are 0: rdata, done, mem_*, busy, grant. The round-robin pointer prefers client 0. A reset mid-transfer abandons the burst; RAM writes already performed stand.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If exactly one start is high, grant that client.
  - If both are high, grant the client that was not granted last.
  - On grant, latch write, address, words, and wdata (clamped count = min(words, MAX_WORDS)).
  - Clear the granted client's rdata to 0.
  - Next state: XFER, or DONE if count = 0.
- XFER: lasts `count` cycles; j = 0..count-1.
  - mem_address = (base + j) mod 2^16, so the address wraps.
  - Write: mem_we = 1 and mem_wdata = latched word j.
  - Read: mem_we = 0. The word addressed in cycle j is captured at the end of cycle j+1 into rdata word j.
  - After the last cycle: write goes to DONE, read goes to DRAIN.
- DRAIN (reads only): one cycle. Captures the last word, drives mem_we = 0, next state DONE.
- Outside XFER, mem_we = 0 and mem_address/mem_wdata hold their last value.
- DONE:
  - Granted client's done = 1 (registered).
  - Stays in DONE while that client's start is high.
  - When start is sampled low, go to IDLE; done falls on that edge.
  - If start was already low on entry, done is high for exactly one cycle.
- Latency, from the edge that samples start in IDLE to done high:
  - write: count + 1 cycles
  - read: count + 2 cycles
  - count = 0: 1 cycle, no RAM access
- Other client's requests:
  - Its start is ignored until the arbiter returns to IDLE.
  - Its done stays 0 and its rdata is untouched.
  - A client whose start is still high in IDLE is re-granted only if it won arbitration, so a client must drop start after done to avoid a repeat transfer.
- Inputs changing mid-transfer: changes to the granted client's address, words, or wdata have no effect (all are latched). Dropping start mid-burst does not abort; the burst completes and done pulses one cycle.
- grant updates on each IDLE grant. busy = (state != IDLE).

Test Plan:
- Single write, then single read: c1 writes 3 words 0xAAAA, 0xBBBB, 0xCCCC at address 0x0010; c1_done rises 4 cycles after start is sampled. c1 then reads 3 words from 0x0010; c1_done rises 5 cycles after start; c1_rdata[255:208] = AAAA_BBBB_CCCC and the rest is 0.
- Simultaneous requests: c0 and c1 start in the same cycle after reset; c0 is served first (grant = 0) and c1 follows immediately after c0 drops start. Repeating with both held high alternates the grants 1, 0, 1.
- Address wrap: a 4-word write at 0xFFFE drives mem_address FFFE, FFFF, 0000, 0001.
- Count boundaries: words = 0 gives done in 1 cycle with mem_we never asserted. words = 40 transfers exactly 16 words.
- Asynchronous reset mid-burst: reset_n is pulsed low during cycle 2 of an 8-word write. mem_we, busy, and done drop without waiting for a clock edge, no further writes occur, and the next start behaves as after power-up.
- Stable done: start is held high for 10 cycles after done. Done stays high, no second transfer occurs, and done falls on the edge that samples start low.
